seg7_display_ctrl: RTL and testbench

SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

---
 rtl/seg7_ctrl_pkg.sv | 32 +++
 rtl/seg7_display_ctrl_tc_counter.sv | 48 ++++
 rtl/seg7_display_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg7_ctrl_pkg
// Shared definitions for the stopwatch 7-segment display controller:
// state encoding, the blank-digit code, mode width and digit bank types.
// -----------------------------------------------------------------------------
package seg7_ctrl_pkg;

  localparam int MODE_W = 2;

  // State encoding doubles as the externally visible mode code.
  localparam logic [MODE_W-1:0] ST_LIVE  = 2'd0;
  localparam logic [MODE_W-1:0] ST_LAP   = 2'd1;
  localparam logic [MODE_W-1:0] ST_BLINK = 2'd2;

  // The 7-segment driver turns a display off when it receives this code.
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic {
    PHASE_OFF = 1'b0,
    PHASE_ON  = 1'b1
  } phase_e;

  typedef logic [3:0] bcd_t;

  // Index 0 is the least significant display (tens of ms).
  typedef bcd_t [3:0] digit_bank_t;

  function automatic digit_bank_t blank_bank();
    return {BLANK_DIGIT, BLANK_DIGIT, BLANK_DIGIT, BLANK_DIGIT};
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_tc_counter.sv
// -----------------------------------------------------------------------------
// tc_counter
// Up-counter running 0..MODULUS-1 with synchronous clear and a terminal-count
// flag. When enabled at the terminal value it wraps to 0, so the count never
// exceeds MODULUS-1.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count enable
//   tc_o   : count equals MODULUS-1
// -----------------------------------------------------------------------------
module tc_counter #(
  parameter int unsigned MODULUS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = $clog2(MODULUS);
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_display_ctrl
// Chooses what the four 7-segment displays of a stopwatch show: the live time,
// a held lap time, or the live time blinking while the stopwatch is stopped.
//
// Ports
//   clk                : system clock, rising edge (50 MHz)
//   rst                : synchronous active-high reset
//   live_d0..live_d3   : live BCD digits (d0 = tens of ms, d3 = tens of s)
//   running            : stopwatch is counting
//   lap_pulse          : one-cycle lap request
//   clear_pulse        : one-cycle clear request
//   digit0..digit3     : registered digits to the display driver (F = blank)
//   lap_valid          : a lap value is stored
//   mode               : current state code (LIVE=0, LAP=1, BLINK=2)
//
// state | meaning
// ------+------------------------------------------------------------
// LIVE  | show live digits; wait for a lap or for the watch to stop
// LAP   | show the captured lap digits until the hold timer expires
// BLINK | watch stopped; alternate live digits and blank displays
// -----------------------------------------------------------------------------
module seg7_display_ctrl
  import seg7_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES       = 100_000_000,
  parameter int unsigned BLINK_HALF_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        live_d0,
  input  logic [3:0]        live_d1,
  input  logic [3:0]        live_d2,
  input  logic [3:0]        live_d3,
  input  logic              running,
  input  logic              lap_pulse,
  input  logic              clear_pulse,
  output logic [3:0]        digit0,
  output logic [3:0]        digit1,
  output logic [3:0]        digit2,
  output logic [3:0]        digit3,
  output logic              lap_valid,
  output logic [MODE_W-1:0] mode
);

  logic [MODE_W-1:0] state_q, state_d;
  digit_bank_t       lap_q, lap_d;
  logic              lap_valid_q, lap_valid_d;
  phase_e            phase_q, phase_d;
  digit_bank_t       digits_q, digits_d;

  digit_bank_t live_w;
  logic        hold_clr, hold_en, hold_tc;
  logic        blink_clr, blink_en, blink_tc;

  assign live_w = {live_d3, live_d2, live_d1, live_d0};

  // Both timers are held at zero outside their own state, so entering LAP or
  // BLINK always starts a fresh interval. A lap request restarts the hold.
  assign hold_en   = (state_q == ST_LAP);
  assign hold_clr  = clear_pulse || lap_pulse || (state_q != ST_LAP);
  assign blink_en  = (state_q == ST_BLINK);
  assign blink_clr = clear_pulse || (state_q != ST_BLINK);

  tc_counter #(
    .MODULUS (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (hold_clr),
    .en_i  (hold_en),
    .tc_o  (hold_tc)
  );

  tc_counter #(
    .MODULUS (BLINK_HALF_CYCLES)
  ) u_blink_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (blink_clr),
    .en_i  (blink_en),
    .tc_o  (blink_tc)
  );

  always_comb begin
    state_d     = state_q;
    lap_d       = lap_q;
    lap_valid_d = lap_valid_q;
    phase_d     = phase_q;

    if (clear_pulse) begin
      lap_d       = '0;
      lap_valid_d = 1'b0;
      state_d     = running ? ST_LIVE : ST_BLINK;
    end else begin
      case (state_q)
        ST_LIVE: begin
          if (lap_pulse && running) begin
            lap_d       = live_w;
            lap_valid_d = 1'b1;
            state_d     = ST_LAP;
          end else if (!running) begin
            state_d = ST_BLINK;
          end
        end
        ST_LAP: begin
          // A new lap outranks the timeout of the previous one.
          if (lap_pulse) begin
            lap_d       = live_w;
            lap_valid_d = 1'b1;
          end else if (hold_tc) begin
            state_d = running ? ST_LIVE : ST_BLINK;
          end
        end
        ST_BLINK: begin
          if (running) begin
            state_d = ST_LIVE;
          end else if (blink_tc) begin
            phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
          end
        end
        default: begin
          state_d = ST_LIVE;
        end
      endcase
    end

    // Phase is only meaningful in BLINK; parking it at ON elsewhere makes
    // every entry into BLINK start with the digits visible.
    if (state_d != ST_BLINK || state_q != ST_BLINK || clear_pulse) begin
      phase_d = PHASE_ON;
    end
  end

  // Display content is decoded from the next state so the registered digits
  // and mode always describe the same state.
  always_comb begin
    digits_d = live_w;
    case (state_d)
      ST_LAP:   digits_d = lap_d;
      ST_BLINK: digits_d = (phase_d == PHASE_ON) ? live_w : blank_bank();
      default:  digits_d = live_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LIVE;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      phase_q     <= PHASE_ON;
      digits_q    <= '0;
    end else begin
      state_q     <= state_d;
      lap_q       <= lap_d;
      lap_valid_q <= lap_valid_d;
      phase_q     <= phase_d;
      digits_q    <= digits_d;
    end
  end

  assign digit0    = digits_q[0];
  assign digit1    = digits_q[1];
  assign digit2    = digits_q[2];
  assign digit3    = digits_q[3];
  assign lap_valid = lap_valid_q;
  assign mode      = state_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
module tb_seg7_display_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] live_d0, live_d1, live_d2, live_d3;
  logic       running, lap_pulse, clear_pulse;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       lap_valid;
  logic [1:0] mode;
  logic [15:0] dig;

  int n_cmp = 0;
  int n_err = 0;

  assign dig = {digit3, digit2, digit1, digit0};

  seg7_display_ctrl #(
    .HOLD_CYCLES       (8),
    .BLINK_HALF_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .live_d0     (live_d0),
    .live_d1     (live_d1),
    .live_d2     (live_d2),
    .live_d3     (live_d3),
    .running     (running),
    .lap_pulse   (lap_pulse),
    .clear_pulse (clear_pulse),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .lap_valid   (lap_valid),
    .mode        (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v is written as d3 d2 d1 d0 in hex.
  task automatic set_live(input logic [15:0] v);
    live_d3 = v[15:12];
    live_d2 = v[11:8];
    live_d1 = v[7:4];
    live_d0 = v[3:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; running = 1'b0; lap_pulse = 1'b0; clear_pulse = 1'b0;
    set_live(16'h9999);
    tick(); tick();
    n_cmp++; if (dig !== 16'h0000) begin n_err++; $display("FAIL reset_digits: got %h expected 0000", dig); end
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    n_cmp++; if (lap_valid !== 1'b0) begin n_err++; $display("FAIL reset_lap_valid: got %b expected 0", lap_valid); end
  endtask

  task automatic test_live();
    running = 1'b1; set_live(16'h4321); rst = 1'b0;
    tick();
    n_cmp++; if (dig !== 16'h4321) begin n_err++; $display("FAIL live_digits: got %h expected 4321", dig); end
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL live_mode: got %0d expected 0", mode); end
    n_cmp++; if (lap_valid !== 1'b0) begin n_err++; $display("FAIL live_lap_valid: got %b expected 0", lap_valid); end
    set_live(16'h1357);
    tick();
    n_cmp++; if (dig !== 16'h1357) begin n_err++; $display("FAIL live_track: got %h expected 1357", dig); end
  endtask

  task automatic test_lap_hold();
    set_live(16'h8765); lap_pulse = 1'b1;
    tick();
    n_cmp++; if (dig !== 16'h8765 || mode !== 2'd1 || lap_valid !== 1'b1)
      begin n_err++; $display("FAIL lap_capture: got %h mode %0d valid %b expected 8765 mode 1 valid 1", dig, mode, lap_valid); end
    lap_pulse = 1'b0; set_live(16'h1111);
    for (int i = 1; i < 8; i++) begin
      tick();
      n_cmp++; if (dig !== 16'h8765 || mode !== 2'd1)
        begin n_err++; $display("FAIL lap_hold[%0d]: got %h mode %0d expected 8765 mode 1", i, dig, mode); end
    end
    tick();
    n_cmp++; if (dig !== 16'h1111 || mode !== 2'd0 || lap_valid !== 1'b1)
      begin n_err++; $display("FAIL lap_timeout: got %h mode %0d valid %b expected 1111 mode 0 valid 1", dig, mode, lap_valid); end
  endtask

  task automatic test_relap();
    set_live(16'h2222); lap_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0; set_live(16'h3333);
    for (int i = 1; i < 8; i++) tick();
    n_cmp++; if (dig !== 16'h2222 || mode !== 2'd1)
      begin n_err++; $display("FAIL relap_before: got %h mode %0d expected 2222 mode 1", dig, mode); end
    // hold count is now at its last value; a lap here must restart the hold
    set_live(16'h9999); lap_pulse = 1'b1;
    tick();
    n_cmp++; if (dig !== 16'h9999 || mode !== 2'd1)
      begin n_err++; $display("FAIL relap_capture: got %h mode %0d expected 9999 mode 1", dig, mode); end
    lap_pulse = 1'b0; set_live(16'h1111);
    for (int i = 1; i < 8; i++) begin
      tick();
      n_cmp++; if (dig !== 16'h9999 || mode !== 2'd1)
        begin n_err++; $display("FAIL relap_hold[%0d]: got %h mode %0d expected 9999 mode 1", i, dig, mode); end
    end
    tick();
    n_cmp++; if (dig !== 16'h1111 || mode !== 2'd0)
      begin n_err++; $display("FAIL relap_timeout: got %h mode %0d expected 1111 mode 0", dig, mode); end
  endtask

  task automatic test_blink();
    logic [15:0] exp_dig;
    running = 1'b0; set_live(16'h0003);
    tick();
    n_cmp++; if (dig !== 16'h0003 || mode !== 2'd2)
      begin n_err++; $display("FAIL blink_enter: got %h mode %0d expected 0003 mode 2", dig, mode); end
    for (int j = 1; j < 12; j++) begin
      lap_pulse = j[0];
      tick();
      exp_dig = (((j / 4) % 2) == 0) ? 16'h0003 : 16'hFFFF;
      n_cmp++; if (dig !== exp_dig || mode !== 2'd2 || lap_valid !== 1'b1)
        begin n_err++; $display("FAIL blink_phase[%0d]: got %h mode %0d valid %b expected %h mode 2 valid 1", j, dig, mode, lap_valid, exp_dig); end
    end
    lap_pulse = 1'b0; running = 1'b1;
    tick();
    n_cmp++; if (dig !== 16'h0003 || mode !== 2'd0)
      begin n_err++; $display("FAIL blink_exit: got %h mode %0d expected 0003 mode 0", dig, mode); end
  endtask

  task automatic test_clear_lap();
    set_live(16'h5555); lap_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0; set_live(16'h7777);
    tick();
    n_cmp++; if (dig !== 16'h5555 || mode !== 2'd1 || lap_valid !== 1'b1)
      begin n_err++; $display("FAIL clear_pre: got %h mode %0d valid %b expected 5555 mode 1 valid 1", dig, mode, lap_valid); end
    clear_pulse = 1'b1; lap_pulse = 1'b1;
    tick();
    n_cmp++; if (dig !== 16'h7777 || mode !== 2'd0 || lap_valid !== 1'b0)
      begin n_err++; $display("FAIL clear_wins: got %h mode %0d valid %b expected 7777 mode 0 valid 0", dig, mode, lap_valid); end
    clear_pulse = 1'b0; lap_pulse = 1'b0;
    tick();
    n_cmp++; if (dig !== 16'h7777 || mode !== 2'd0 || lap_valid !== 1'b0)
      begin n_err++; $display("FAIL clear_after: got %h mode %0d valid %b expected 7777 mode 0 valid 0", dig, mode, lap_valid); end
  endtask

  task automatic test_reset_mid_blink();
    set_live(16'h0003); running = 1'b1; lap_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0; running = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    n_cmp++; if (dig !== 16'h0003 || mode !== 2'd1)
      begin n_err++; $display("FAIL lap_stop_hold: got %h mode %0d expected 0003 mode 1", dig, mode); end
    tick();
    n_cmp++; if (dig !== 16'h0003 || mode !== 2'd2 || lap_valid !== 1'b1)
      begin n_err++; $display("FAIL lap_to_blink: got %h mode %0d valid %b expected 0003 mode 2 valid 1", dig, mode, lap_valid); end
    for (int j = 1; j < 6; j++) tick();
    n_cmp++; if (dig !== 16'hFFFF || mode !== 2'd2)
      begin n_err++; $display("FAIL blink_off: got %h mode %0d expected FFFF mode 2", dig, mode); end
    rst = 1'b1;
    tick();
    n_cmp++; if (dig !== 16'h0000 || mode !== 2'd0 || lap_valid !== 1'b0)
      begin n_err++; $display("FAIL rst_mid_blink: got %h mode %0d valid %b expected 0000 mode 0 valid 0", dig, mode, lap_valid); end
    rst = 1'b0;
    tick();
    n_cmp++; if (dig !== 16'h0003 || mode !== 2'd2)
      begin n_err++; $display("FAIL rst_blink_restart: got %h mode %0d expected 0003 mode 2", dig, mode); end
    for (int j = 1; j < 4; j++) tick();
    n_cmp++; if (dig !== 16'h0003)
      begin n_err++; $display("FAIL rst_blink_on_len: got %h expected 0003", dig); end
    tick();
    n_cmp++; if (dig !== 16'hFFFF)
      begin n_err++; $display("FAIL rst_blink_off: got %h expected FFFF", dig); end
  endtask

  initial begin
    rst = 1'b1; running = 1'b0; lap_pulse = 1'b0; clear_pulse = 1'b0;
    set_live(16'h0000);
    test_reset();
    test_live();
    test_lap_hold();
    test_relap();
    test_blink();
    test_clear_lap();
    test_reset_mid_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
